// File: rtl/game_pkg.sv
// Shared definitions for the obstacle scheduler: FSM states, difficulty level codes and lane mapping.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_PAUSED   = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic [1:0] LVL_EASY    = 2'd0;
    localparam logic [1:0] LVL_NORMAL  = 2'd1;
    localparam logic [1:0] LVL_EXTREME = 2'd2;

    localparam int NUM_LANES = 5;

    // Fold a 3-bit random value onto lanes 0..NUM_LANES-1 (5,6,7 -> 0,1,2).
    function automatic logic [2:0] lane_fold(input logic [2:0] raw);
        return (raw < 3'(NUM_LANES)) ? raw : raw - 3'(NUM_LANES);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Game-tick prescaler: counts enabled cycles 0..TICK_DIV-1 and pulses tick on the last count.
module tick_gen #(
    parameter logic [15:0] TICK_DIV = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [15:0] r_cnt;
    logic        w_wrap;

    assign w_wrap = (r_cnt == TICK_DIV - 16'd1);
    assign tick   = en && w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_wrap ? 16'd0 : r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle spawn scheduler: turns game ticks and LFSR trigger bits into acknowledged spawn requests.
module obstacle_scheduler #(
    parameter logic [15:0] TICK_DIV   = 16'd50000,
    parameter logic [3:0]  EASY_P     = 4'd8,
    parameter logic [3:0]  NORMAL_P   = 4'd4,
    parameter logic [3:0]  EXTREME_P  = 4'd2,
    parameter logic [7:0]  MAX_SPAWNS = 8'd200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic [1:0] level,
    input  logic [4:0] prn,
    input  logic       easy_t,
    input  logic       normal_t,
    input  logic       extreme_t,
    input  logic       spawn_ack,
    output logic       spawn_req,
    output logic [2:0] spawn_lane,
    output logic [7:0] spawn_cnt,
    output logic       busy,
    output logic       done
);

    import game_pkg::*;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_lvl;
    logic [3:0]  r_per;
    logic        r_req;
    logic [2:0]  r_lane;
    logic [7:0]  r_cnt;

    logic        w_active;
    logic        w_tick;
    logic        w_opp;
    logic        w_trig;
    logic [3:0]  w_period;
    logic        w_clr;
    logic        w_spawn;
    logic        w_ack;
    logic [1:0]  w_prn_unused;

    assign w_prn_unused = prn[4:3];

    // A resuming PAUSED cycle counts like RUN so a pause shifts the schedule by exactly its length.
    assign w_active = ((r_state == ST_RUN) || (r_state == ST_PAUSED)) && !pause;
    assign w_opp    = w_tick && (r_per == w_period - 4'd1);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_active),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    always_comb begin
        w_period = NORMAL_P;
        w_trig   = normal_t;
        case (r_lvl)
            LVL_EASY: begin
                w_period = EASY_P;
                w_trig   = easy_t;
            end
            LVL_EXTREME: begin
                w_period = EXTREME_P;
                w_trig   = extreme_t;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_spawn     = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_clr       = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN, ST_PAUSED: begin
                if (pause) begin
                    w_state_nxt = ST_PAUSED;
                end else if (w_opp && w_trig) begin
                    w_spawn     = 1'b1;
                    w_state_nxt = ST_WAIT_ACK;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_WAIT_ACK: begin
                if (spawn_ack) begin
                    w_ack = 1'b1;
                    if (r_cnt + 8'd1 == MAX_SPAWNS) begin
                        w_state_nxt = ST_DONE;
                    end else if (pause) begin
                        w_state_nxt = ST_PAUSED;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl  <= LVL_NORMAL;
            r_per  <= '0;
            r_req  <= 1'b0;
            r_lane <= '0;
            r_cnt  <= '0;
        end else if (w_clr) begin
            r_lvl <= (level == 2'd3) ? LVL_NORMAL : level;
            r_per <= '0;
            r_cnt <= '0;
        end else begin
            if (w_tick) begin
                r_per <= w_opp ? 4'd0 : r_per + 4'd1;
            end
            if (w_spawn) begin
                r_req  <= 1'b1;
                r_lane <= lane_fold(prn[2:0]);
            end
            if (w_ack) begin
                r_req <= 1'b0;
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign spawn_req  = r_req;
    assign spawn_lane = r_lane;
    assign spawn_cnt  = r_cnt;
    assign busy       = (r_state == ST_RUN) || (r_state == ST_WAIT_ACK) || (r_state == ST_PAUSED);
    assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_obstacle_scheduler;

    localparam int TD   = 4;
    localparam int MAXS = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] level = 2'd0;
    logic [4:0] prn = 5'd0;
    logic       easy_t = 1'b0;
    logic       normal_t = 1'b0;
    logic       extreme_t = 1'b0;
    logic       spawn_ack = 1'b0;
    logic       spawn_req;
    logic [2:0] spawn_lane;
    logic [7:0] spawn_cnt;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0 idle, 1 running, 2 waiting for ack, 3 paused, 4 finished.
    int m_mode = 0;
    int m_act  = 0;
    int m_lvl  = 1;
    int m_req  = 0;
    int m_lane = 0;
    int m_cnt  = 0;

    obstacle_scheduler #(
        .TICK_DIV   (16'(TD)),
        .EASY_P     (4'd8),
        .NORMAL_P   (4'd4),
        .EXTREME_P  (4'd2),
        .MAX_SPAWNS (8'(MAXS))
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pause      (pause),
        .level      (level),
        .prn        (prn),
        .easy_t     (easy_t),
        .normal_t   (normal_t),
        .extreme_t  (extreme_t),
        .spawn_ack  (spawn_ack),
        .spawn_req  (spawn_req),
        .spawn_lane (spawn_lane),
        .spawn_cnt  (spawn_cnt),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int period_of(input int lv);
        if (lv == 0) return 8;
        if (lv == 2) return 2;
        return 4;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_act = 0; m_lvl = 1; m_req = 0; m_lane = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        int trig;
        case (m_mode)
            0, 4: if (start) begin
                m_lvl  = (level == 2'd3) ? 1 : int'(level);
                m_act  = 0;
                m_cnt  = 0;
                m_mode = 1;
            end
            1, 3: if (pause) begin
                m_mode = 3;
            end else begin
                m_mode = 1;
                m_act++;
                if ((m_act % TD == 0) && ((m_act / TD) % period_of(m_lvl) == 0)) begin
                    trig = (m_lvl == 0) ? int'(easy_t) : (m_lvl == 2) ? int'(extreme_t) : int'(normal_t);
                    if (trig != 0) begin
                        m_req  = 1;
                        m_lane = (int'(prn) & 7) % 5;
                        m_mode = 2;
                    end
                end
            end
            2: if (spawn_ack) begin
                m_req = 0;
                m_cnt++;
                if (m_cnt == MAXS)  m_mode = 4;
                else if (pause)     m_mode = 3;
                else                m_mode = 1;
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic compare_all();
        check_eq("spawn_req",  int'(spawn_req),  m_req);
        check_eq("spawn_lane", int'(spawn_lane), m_lane);
        check_eq("spawn_cnt",  int'(spawn_cnt),  m_cnt);
        check_eq("busy",       int'(busy),       (m_mode >= 1 && m_mode <= 3) ? 1 : 0);
        check_eq("done",       int'(done),       (m_mode == 4) ? 1 : 0);
    endtask

    // Called at a falling edge: drive inputs, advance the model over the next rising edge, compare.
    task automatic step(input logic s, input logic p, input logic [1:0] lv, input logic [4:0] pr,
                        input logic et, input logic nt, input logic xt, input logic ak);
        start = s; pause = p; level = lv; prn = pr;
        easy_t = et; normal_t = nt; extreme_t = xt; spawn_ack = ak;
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Reset asserted between clock edges; outputs must clear before any rising edge occurs.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        start = 0; pause = 0; spawn_ack = 0; easy_t = 0; normal_t = 0; extreme_t = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        model_reset();
        @(negedge clk);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Extreme level, trigger always set: spawn after the 2nd tick on lane 1.
        step(1, 0, 2'd2, 5'b00110, 0, 0, 1, 0);
        n = 0;
        while (!spawn_req && n < 40) begin
            step(0, 0, 2'd0, 5'b00110, 0, 0, 1, 0);
            n++;
        end
        check_eq("lat_extreme", n, 8);
        check_eq("lane_extreme", int'(spawn_lane), 1);

        // Ack withheld: request and lane stay put, no schedule progress.
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 2'd1, 5'($urandom), 0, 0, 1, 0);
            check_eq("hold_req", int'(spawn_req), 1);
            check_eq("hold_lane", int'(spawn_lane), 1);
        end
        step(0, 0, 2'd1, 5'd7, 0, 0, 1, 1);
        check_eq("ack_cnt", int'(spawn_cnt), 1);
        check_eq("ack_req", int'(spawn_req), 0);
        n = 0;
        while (!spawn_req && n < 40) begin
            step(0, 0, 2'd0, 5'd7, 0, 0, 1, 0);
            n++;
        end
        check_eq("lat_after_ack", n, 8);

        // Immediate acks until the round limit.
        n = 0;
        while (!done && n < 100) begin
            step(0, 0, 2'd0, 5'($urandom), 0, 0, 1, 1);
            n++;
        end
        check_eq("done_flag", int'(done), 1);
        check_eq("done_cnt", int'(spawn_cnt), MAXS);
        step(1, 0, 2'd2, 5'd0, 0, 0, 1, 0);
        check_eq("restart_cnt", int'(spawn_cnt), 0);
        check_eq("restart_busy", int'(busy), 1);

        // Reset while a request is pending.
        n = 0;
        while (!spawn_req && n < 40) begin
            step(0, 0, 2'd0, 5'd3, 0, 0, 1, 0);
            n++;
        end
        check_eq("pre_reset_req", int'(spawn_req), 1);
        async_reset();

        // Easy level: three empty opportunities, spawn on the fourth.
        step(1, 0, 2'd0, 5'd4, 0, 0, 0, 0);
        n = 0;
        while (!spawn_req && n < 200) begin
            step(0, 0, 2'd0, 5'd4, (n + 1 > 96) ? 1'b1 : 1'b0, 0, 0, 0);
            n++;
        end
        check_eq("lat_easy", n, 128);
        async_reset();

        // Normal level: a 50-cycle pause shifts the opportunity by 50 cycles.
        step(1, 0, 2'd3, 5'd2, 0, 1, 0, 0);
        n = 0;
        while (!spawn_req && n < 200) begin
            step(0, (n >= 5 && n < 55) ? 1'b1 : 1'b0, 2'd0, 5'd2, 0, 1, 0, 0);
            n++;
        end
        check_eq("lat_pause", n, 66);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                step(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0), 2'($urandom),
                     5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 2) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 16'd50000: clk cycles per game tick (legal range 2..65535).
REQ-002 Parameter EASY_P / NORMAL_P / EXTREME_P, defaults 4'd8 / 4'd4 / 4'd2: ticks per spawn opportunity per level (legal range 1..15).
REQ-003 Parameter MAX_SPAWNS, default 8'd200: spawns per round before DONE (legal range 1..255).
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  level-sensitive; begins or restarts a round.
REQ-007 pause  in  1  level-sensitive; freezes the round while high.
REQ-008 level  in  2  0 easy, 1 normal, 2 extreme, 3 treated as normal.
REQ-009 prn  in  5  pseudo-random word from the free-running 5-bit LFSR.
REQ-010 easy_t, normal_t, extreme_t  in  1 each  LFSR-derived spawn-trigger bits.
REQ-011 spawn_ack  in  1  consumer accepts the current spawn.
REQ-012 spawn_req  out  1  spawn request, held until acknowledged.
REQ-013 spawn_lane  out  3  lane 0..4 of the request.
REQ-014 spawn_cnt  out  8  spawns accepted this round.
REQ-015 busy  out  1  high in RUN, WAIT_ACK, PAUSED.
REQ-016 done  out  1  high in DONE.

Function
REQ-017 States: IDLE, RUN, WAIT_ACK, PAUSED, DONE.
REQ-018 IDLE: start=1 -> latch level into lvl_q, clear prescaler, period counter, spawn_cnt -> RUN next cycle.
REQ-019 level is sampled only on the IDLE/DONE->RUN transition; changes mid-round are ignored.
REQ-020 RUN: prescaler counts 0..TICK_DIV-1 and wraps; tick = one-cycle pulse at count TICK_DIV-1.
REQ-021 On each tick the period counter increments; at period P-1 (P selected by lvl_q) it wraps to 0 and forms a spawn opportunity.
REQ-022 At an opportunity, the trigger is easy_t / normal_t / extreme_t as selected by lvl_q, sampled that cycle.
REQ-023 Trigger=1: spawn_lane <= prn[2:0] if <5, else prn[2:0]-5; spawn_req <= 1; -> WAIT_ACK.
REQ-024 Trigger=0: opportunity is discarded; stay in RUN; no output change.
REQ-025 WAIT_ACK: spawn_req and spawn_lane held stable; prescaler and period counter frozen.
REQ-026 spawn_ack=1 in WAIT_ACK: spawn_req <= 0, spawn_cnt += 1, -> DONE if new count == MAX_SPAWNS, else -> RUN.
REQ-027 spawn_ack is ignored outside WAIT_ACK; spawn_req deasserts exactly one cycle after ack is seen.
REQ-028 RUN with pause=1 -> PAUSED; prescaler, period counter, spawn_cnt frozen; PAUSED with pause=0 -> RUN, counting resumes from frozen values.
REQ-029 pause during WAIT_ACK is deferred: after ack, go to PAUSED instead of RUN if pause=1, unless the count reached MAX_SPAWNS (DONE wins).
REQ-030 A tick coinciding with the RUN->PAUSED transition is dropped (pause has priority over tick).
REQ-031 DONE: done=1, spawn_cnt held; start=1 -> same actions as REQ-018.
REQ-032 start is ignored in RUN, WAIT_ACK, PAUSED; start and pause both high in IDLE -> RUN, then PAUSED the following cycle.
REQ-033 spawn_cnt never wraps; bounded by MAX_SPAWNS.

Reset
REQ-034 rst_n=0 asynchronously forces IDLE, spawn_req=0, spawn_lane=0, spawn_cnt=0, busy=0, done=0, all counters 0, lvl_q=normal.
REQ-035 Reset asserted mid-round (including WAIT_ACK) aborts the round with no further spawn_req; operation resumes on the first clk edge after rst_n rises.

Structure
REQ-036 State encoding, level codes and lane count (5) live in a shared package, game_pkg.
REQ-037 The tick prescaler is a sub-module, tick_gen (parameter TICK_DIV; inputs clk, rst_n, en, clr; output tick).
REQ-038 The LFSR is external; this block only samples prn and the trigger bits and never drives the LFSR.

Verification
REQ-039 TICK_DIV=4, level=2, extreme_t=1, prn=5'b00110 -> spawn_req rises on the cycle after the 2nd tick, spawn_lane=1.
REQ-040 TICK_DIV=4, level=0, easy_t held 0 for 3 opportunities then 1 -> exactly one spawn_req, at the 4th opportunity.
REQ-041 spawn_ack withheld 20 cycles -> spawn_req and spawn_lane stable, no ticks counted; ack -> spawn_cnt +1, req low next cycle.
REQ-042 pause high mid-period for 50 cycles -> counters frozen; release -> next opportunity shifted by exactly 50 cycles.
REQ-043 MAX_SPAWNS=3, trigger always 1, immediate ack -> done=1 after 3rd ack, spawn_cnt=3; start -> spawn_cnt=0, busy=1.
REQ-044 rst_n pulsed low in WAIT_ACK -> spawn_req=0, spawn_cnt=0, IDLE immediately, without waiting for a clk edge.
